// File: rtl/dot_mac_pkg.sv
// Shared types and width helpers for the serial dot-product engine.
package dot_mac_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  function automatic int calc_beats(input int n, input int lanes);
    return n / lanes;
  endfunction

  function automatic int calc_ow(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/dot_mac_lane_tree.sv
// Combinational LANES-wide multiply and balanced adder tree for one beat.
module dot_mac_lane_tree #(
  parameter int DW     = 4,
  parameter int LANES  = 8,
  parameter int SIGNED = 0
) (
  input  logic [LANES*DW-1:0]             a_i,
  input  logic [LANES*DW-1:0]             b_i,
  output logic [2*DW+$clog2(LANES)-1:0]   sum_o
);

  localparam int SW  = 2 * DW + $clog2(LANES);
  localparam int LVL = $clog2(LANES);
  localparam int P   = 1 << LVL;

  // Heap-ordered tree: leaves at P-1.., node n sums children 2n+1 and 2n+2.
  logic [SW-1:0] node_s [2*P-1];

  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < LANES) begin : g_mul
      logic [DW-1:0]   a_s;
      logic [DW-1:0]   b_s;
      logic [2*DW-1:0] prod_s;
      assign a_s = a_i[(LANES-1-k)*DW +: DW];
      assign b_s = b_i[(LANES-1-k)*DW +: DW];
      if (SIGNED != 0) begin : g_sgn
        assign prod_s            = (2*DW)'($signed(a_s)) * (2*DW)'($signed(b_s));
        assign node_s[P-1+k]     = SW'($signed(prod_s));
      end else begin : g_uns
        assign prod_s            = (2*DW)'(a_s) * (2*DW)'(b_s);
        assign node_s[P-1+k]     = SW'(prod_s);
      end
    end else begin : g_pad
      assign node_s[P-1+k] = '0;
    end
  end

  for (genvar n = 0; n < P - 1; n++) begin : g_add
    assign node_s[n] = node_s[2*n+1] + node_s[2*n+2];
  end

  assign sum_o = node_s[0];

endmodule

// File: rtl/dot_mac_serial.sv
// Serial dot-product engine: N-element vectors over N/LANES beats, retained
// per-beat weights, abort on a mid-vector gap, result two cycles after last beat.
module dot_mac_serial
  import dot_mac_pkg::*;
#(
  parameter int DW     = 4,
  parameter int N      = 32,
  parameter int LANES  = 8,
  parameter int SIGNED = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        weight_valid,
  input  logic [LANES*DW-1:0]         I,
  input  logic [LANES*DW-1:0]         W,
  output logic                        out_valid,
  output logic [calc_ow(DW, N)-1:0]   OUT,
  output logic                        err
);

  localparam int BEATS = calc_beats(N, LANES);
  localparam int OW    = calc_ow(DW, N);
  localparam int SW    = 2 * DW + $clog2(LANES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

  state_e              state_q, state_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [LANES*DW-1:0] wmem_q [BEATS];

  logic                accept_s, abort_s, first_s, last_s;
  logic [BW-1:0]       beat_idx_s;
  logic [LANES*DW-1:0] eff_w_s;
  logic [SW-1:0]       lane_sum_s;
  logic [OW-1:0]       sum_ext_s;

  logic                s1_valid_q, s1_first_q, s1_last_q;
  logic [SW-1:0]       s1_sum_q;
  logic [OW-1:0]       acc_q, acc_d;
  logic                s2_last_q, abort_q;
  logic                out_valid_q, err_q;
  logic [OW-1:0]       out_q;

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next state: a gap in RECV aborts, the final beat returns to IDLE.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && (BEATS > 1)) begin
          state_d = RECV;
          bcnt_d  = BW'(1);
        end else begin
          state_d = IDLE;
          bcnt_d  = '0;
        end
      end
      RECV: begin
        if (in_valid && (bcnt_q != LAST_IDX)) begin
          state_d = RECV;
          bcnt_d  = bcnt_q + BW'(1);
        end else begin
          state_d = IDLE;
          bcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // FSM outputs: beat acceptance, beat index and abort detection.
  always_comb begin
    accept_s   = in_valid;
    abort_s    = 1'b0;
    beat_idx_s = '0;
    case (state_q)
      IDLE: begin
        beat_idx_s = '0;
      end
      RECV: begin
        beat_idx_s = bcnt_q;
        abort_s    = ~in_valid;
      end
      default: begin
        beat_idx_s = '0;
        accept_s   = 1'b0;
      end
    endcase
    first_s = (beat_idx_s == '0);
    last_s  = (beat_idx_s == LAST_IDX);
    eff_w_s = weight_valid ? W : wmem_q[beat_idx_s];
  end

  // Weight store; writes from aborted vectors are kept on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BEATS; b++) begin
        wmem_q[b] <= '0;
      end
    end else if (accept_s && weight_valid) begin
      wmem_q[beat_idx_s] <= W;
    end
  end

  dot_mac_lane_tree #(
    .DW     (DW),
    .LANES  (LANES),
    .SIGNED (SIGNED)
  ) u_tree (
    .a_i   (I),
    .b_i   (eff_w_s),
    .sum_o (lane_sum_s)
  );

  // Accumulator next value: first beat loads, later beats add.
  always_comb begin
    if (SIGNED != 0) begin
      sum_ext_s = OW'($signed(s1_sum_q));
    end else begin
      sum_ext_s = OW'(s1_sum_q);
    end
    if (s1_valid_q && s1_first_q) begin
      acc_d = sum_ext_s;
    end else if (s1_valid_q) begin
      acc_d = acc_q + sum_ext_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // S1/S2 pipeline and output registers; OUT is forced to zero when not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      s2_last_q   <= 1'b0;
      abort_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= accept_s;
      s1_first_q  <= first_s;
      s1_last_q   <= last_s;
      s1_sum_q    <= lane_sum_s;
      acc_q       <= acc_d;
      s2_last_q   <= s1_valid_q & s1_last_q;
      abort_q     <= abort_s;
      out_valid_q <= s2_last_q;
      out_q       <= s2_last_q ? acc_q : '0;
      err_q       <= abort_q;
    end
  end

  assign out_valid = out_valid_q;
  assign OUT       = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dot_mac_serial.sv
// Scoreboard bench for dot_mac_serial: expected results and error pulses are
// queued with their due cycle and compared every cycle on the falling edge.
module tb_dot_mac_serial;

  typedef struct {
    int          cyc;
    logic [12:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        weight_valid = 1'b0;
  logic [31:0] I = 32'd0;
  logic [31:0] W = 32'd0;
  logic        out_valid, err;
  logic [12:0] OUT;
  logic        s_out_valid, s_err;
  logic [12:0] s_OUT;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        exp_q[$];
  int          err_q[$];
  logic [31:0] wmodel [4];

  dot_mac_serial u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .weight_valid (weight_valid),
    .I            (I),
    .W            (W),
    .out_valid    (out_valid),
    .OUT          (OUT),
    .err          (err)
  );

  dot_mac_serial #(.SIGNED(1)) u_sdut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .weight_valid (weight_valid),
    .I            (I),
    .W            (W),
    .out_valid    (s_out_valid),
    .OUT          (s_OUT),
    .err          (s_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, got, got, want, want, cyc);
  endtask

  function automatic logic [31:0] rep4(input logic [3:0] v);
    return {8{v}};
  endfunction

  // Drive nb beats (nb<4 aborts); beat b uses ib/wb[b*32 +: 32], wm[b] = weight_valid.
  task automatic send_vec(input logic [127:0] ib, input logic [127:0] wb,
                          input logic [3:0] wm, input int nb);
    int          acc;
    logic [31:0] iw, ww;
    acc = 0;
    for (int b = 0; b < nb; b++) begin
      iw = ib[b*32 +: 32];
      if (wm[b]) wmodel[b] = wb[b*32 +: 32];
      ww = wmodel[b];
      for (int k = 0; k < 8; k++) acc += int'(iw[k*4 +: 4]) * int'(ww[k*4 +: 4]);
      @(negedge clk);
      in_valid     = 1'b1;
      I            = iw;
      W            = wb[b*32 +: 32];
      weight_valid = wm[b];
      if (b == 3) exp_q.push_back('{cyc + 3, 13'(acc)});
    end
    if (nb < 4) begin
      @(negedge clk);
      in_valid     = 1'b0;
      weight_valid = 1'b0;
      err_q.push_back(cyc + 2);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid     = 1'b0;
      weight_valid = 1'b0;
    end
  endtask

  function automatic logic [127:0] all4(input logic [3:0] v);
    return {rep4(v), rep4(v), rep4(v), rep4(v)};
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("OUT", 32'(OUT), 32'(e.val));
    end else begin
      chk("no_out_valid", 32'(out_valid), 32'd0);
      chk("OUT_zero", 32'(OUT), 32'd0);
    end
    if (err_q.size() > 0 && err_q[0] == cyc) begin
      void'(err_q.pop_front());
      chk("err", 32'(err), 32'd1);
    end else begin
      chk("no_err", 32'(err), 32'd0);
    end
  end

  initial begin
    for (int b = 0; b < 4; b++) wmodel[b] = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a vector drops everything in flight.
    @(negedge clk);
    in_valid = 1'b1; I = rep4(4'hF); W = rep4(4'hF); weight_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    weight_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_OUT", 32'(OUT), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    // Full load of 15s, then reuse of stored weights back-to-back.
    send_vec(all4(4'hF), all4(4'hF), 4'b1111, 4);
    send_vec(all4(4'h1), all4(4'h0), 4'b0000, 4);
    idle(2);

    // Back-to-back vectors with W=1 loaded in the first one.
    send_vec(all4(4'h2), all4(4'h1), 4'b1111, 4);
    send_vec(all4(4'h3), all4(4'h0), 4'b0000, 4);
    idle(3);

    // Abort after two beats; weight writes of beats 0/1 persist.
    send_vec(all4(4'h5), all4(4'h2), 4'b1111, 2);
    idle(2);
    send_vec(all4(4'h1), all4(4'h0), 4'b0000, 4);
    send_vec(all4(4'h1), all4(4'h1), 4'b1111, 4);

    // Partial reload of beat 2 only.
    send_vec(all4(4'h1), all4(4'h3), 4'b0100, 4);
    idle(2);

    // Signed instance: -8 * 7 * 32 = -1792.
    send_vec(all4(4'h8), all4(4'h7), 4'b1111, 4);
    idle(3);
    chk("s_out_valid", 32'(s_out_valid), 32'd1);
    chk("s_OUT", 32'(s_OUT), 32'h1900);
    chk("s_err", 32'(s_err), 32'd0);

    // Random vectors with random reload masks.
    for (int r = 0; r < 8; r++) begin
      send_vec({$urandom(), $urandom(), $urandom(), $urandom()},
               {$urandom(), $urandom(), $urandom(), $urandom()},
               4'($urandom_range(0, 15)), 4);
    end
    idle(6);
    chk("sb_empty", 32'(exp_q.size() + err_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dot_mac_serial.md
# dot_mac_serial

Parametrised serial-input dot-product engine: accepts an N-element activation vector and optional N-element weight vector over N/LANES consecutive beats, multiplies element-wise, and emits the full-vector sum. Successor of the single-beat 32x4-bit dot-product unit in the final-project datapath. Adds a configurable beat width, a signed mode, per-beat weight retention (weights reused when not reloaded) and mid-vector abort. Sits between the input stream formatter and the result collector.

## Interface
- DW, 4, element width of I and W lanes (bits)
- N, 32, vector length (elements); N % LANES == 0
- LANES, 8, elements per input beat
- SIGNED, 0, 0 = unsigned operands/result, 1 = two's-complement operands/result
- Derived: BEATS = N/LANES; OW = 2*DW + clog2(N) (13 at defaults)

- clk  in  1  single clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  activation beat valid
- weight_valid  in  1  weight beat valid; sampled only when in_valid=1
- I  in  LANES*DW  activation beat; lane k = I[(LANES-1-k)*DW +: DW] (element 0 in MSBs)
- W  in  LANES*DW  weight beat, same lane order
- out_valid  out  1  result valid, one-cycle pulse
- OUT  out  OW  dot-product result
- err  out  1  one-cycle pulse on aborted vector

## Operation
- FSM states: IDLE, RECV. Beat counter bcnt (clog2(BEATS) bits).
- IDLE: in_valid=1 -> beat 0 taken, bcnt=1, go RECV (BEATS=1: vector completes immediately, stay IDLE).
- RECV: in_valid=1 -> take beat bcnt; if bcnt==BEATS-1, vector complete, bcnt=0, go IDLE. in_valid=0 -> abort: bcnt=0, partial sum discarded, err=1 next cycle, go IDLE.
- Weights: storage wmem[BEATS] of LANES*DW bits. Per accepted beat b: effective weight = weight_valid ? W : wmem[b]; if weight_valid, wmem[b] <= W. Partial reloads (some beats only) are legal.
- Aborted vector: weight writes already performed persist.
- Product: DW x DW -> 2*DW, signed or unsigned per SIGNED; lane sum of LANES products; accumulator OW bits. No overflow possible by width rule; no saturation.
- Back-to-back vectors: a new beat 0 is accepted in the cycle after the previous vector's last beat, no bubble.
- out_valid=0 -> OUT=0 (OUT is never stale).

## Timing
- Reset (asynchronous): out_valid=0, OUT=0, err=0, state=IDLE, bcnt=0, wmem=0, pipeline valids cleared. Reset mid-vector drops all in-flight work; no out_valid after release.
- Pipeline: S1 register = lane-sum of beat + beat-last/first flags; S2 = accumulator (first beat loads, others add); on last beat S2 value drives OUT register.
- Latency: last beat sampled at edge t -> out_valid=1 and OUT valid from edge t+2, for exactly one cycle.
- Throughput: one vector per BEATS cycles.
- err: abort detected at edge t (in_valid=0 in RECV) -> err=1 from edge t+1 for one cycle. The in-flight S1 beat of the aborted vector must not reach OUT.

## Structure
- Package dot_mac_pkg: state enum (IDLE, RECV), functions for BEATS and OW derivation.
- Sub-module dot_mac_lane_tree: LANES multipliers + balanced adder tree, combinational, parametrised by DW, LANES, SIGNED; output width 2*DW+clog2(LANES).
- Top holds FSM, bcnt, wmem, S1/S2 registers, output regs.

## Test plan
- Reset: assert rst_n=0 mid-RECV -> out_valid=0, OUT=0, err=0; no spurious out_valid after release.
- Defaults, all I=4'hF, W=4'hF, weight_valid=1 on 4 beats -> OUT=7200 two cycles after beat 3, single-cycle pulse.
- Weight reuse: next vector I=1 all, weight_valid=0 -> OUT=480 (uses stored 15s).
- Back-to-back: W=1 loaded, then I=2 vector immediately followed by I=3 vector -> OUT=64 then OUT=96, out_valid pulses 4 cycles apart.
- Abort: in_valid drops after beat 1 -> err pulse one cycle later, no out_valid; following full vector I=1,W=1 -> OUT=32.
- SIGNED=1: I=4'h8 (-8), W=4'h7 all elements -> OUT=13'h1900 (-1792).
